// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with a bounded tenure.
//
// Purpose:
//   Grants one shared downstream resource to one of four level-sensitive
//   requesters. The search for the next owner starts just after the last
//   owner and wraps 3 -> 0, so every requester is eventually served. A
//   hold counter limits how long one owner may keep the grant. When the
//   limit is reached the grant rotates, and EXPIRE pulses for one cycle.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous, active-high reset
//   REQ     in   4  request vector, bit i = requester i
//   GNT     out  4  registered one-hot grant, zero when idle
//   GNT_ID  out  2  encoded owner index, zero when idle
//   VALID   out  1  a grant is active (OR of GNT)
//   EXPIRE  out  1  one-cycle pulse after a tenure ended by the hold limit
//
// Parameters:
//   MAX_HOLD  maximum consecutive granted cycles per tenure (1..15)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD

module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       VALID,
  output logic       EXPIRE
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE   = CNT_W'(1);

  state_t           state_q,  state_d;
  logic [3:0]       gnt_q,    gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       last_q,   last_d;
  logic [CNT_W-1:0] hold_q,   hold_d;
  logic             expire_q, expire_d;

  // Round-robin search. Candidates are base+1, base+2, base+3, base+4
  // (mod 4). The base itself is tried last, so an expiring owner is
  // re-granted only when nobody else is asking.
  logic [1:0] search_base;
  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    logic [1:0] cand;
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = search_base + 2'(k);
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // When idle, the search resumes after the last owner. While granted,
  // every non-continue outcome makes the current owner the new LAST, so
  // the search starts after the owner.
  assign search_base = (state_q == GRANT) ? gnt_id_q : last_q;

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
    hold_d   = hold_q;
    expire_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = GRANT;
          gnt_id_d = pick_idx;
          hold_d   = HOLD_ONE;
        end
      end

      GRANT: begin
        if (REQ[gnt_id_q] && (hold_q < HOLD_LIMIT)) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          // Either a release or an expiry. If REQ is still high, the hold
          // limit ended this tenure.
          last_d   = gnt_id_q;
          expire_d = REQ[gnt_id_q];
          if (pick_found) begin
            gnt_id_d = pick_idx;
            hold_d   = HOLD_ONE;
          end else begin
            state_d  = IDLE;
            gnt_id_d = 2'd0;
            hold_d   = '0;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        gnt_id_d = 2'd0;
        hold_d   = '0;
      end
    endcase

    gnt_d = (state_d == GRANT) ? (4'b0001 << gnt_id_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      last_q   <= 2'd3;
      hold_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      expire_q <= expire_d;
    end
  end

  assign GNT    = gnt_q;
  assign GNT_ID = gnt_id_q;
  assign VALID  = |gnt_q;
  assign EXPIRE = expire_q;

endmodule
